bin2bcd_seq: RTL

- Iterative, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Replaces the fixed 8-bit combinational add3 array with a width- and digit-generic sequential engine.
- Handles signed (two's complement) or unsigned operands, selected per conversion.
- Uses a start/busy/done handshake and feeds the per-digit BCDto7seg decoders downstream.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bin2bcd_seq_if.sv | 41 ++++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin2bcd_seq.sv | 109 ++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, counter sizing and FSM state type for the sequential binary-to-BCD engine.
// Pure declarations: no latency, no flow control.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADJ_VALUE = 4'd3;

  // The counter only ever holds WORD_LENGTH-1, so $clog2 of the width is enough.
  function automatic int cnt_width(input int wordLength);
    return (wordLength <= 2) ? 1 : $clog2(wordLength);
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done request and result bundle of bin2bcd_seq; the requester drives master.
// Latency and backpressure are defined by the converter: start is ignored while busy is high.
interface bin2bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int DIGITS      = 5
);

  logic                           start;
  logic                           is_signed;
  logic [WORD_LENGTH-1:0]         bin;
  logic                           busy;
  logic                           done;
  logic [BCD_DIGIT_W*DIGITS-1:0]  bcd;
  logic                           negative;
  logic                           ovf;

  modport master (
    output start,
    output is_signed,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  negative,
    input  ovf
  );

  modport slave (
    input  start,
    input  is_signed,
    input  bin,
    output busy,
    output done,
    output bcd,
    output negative,
    output ovf
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added before the shift.
// Purely combinational, zero latency, no flow control.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digitIn,
  output logic [BCD_DIGIT_W-1:0] digitOut
);

  always_comb begin
    digitOut = digitIn;
    if (digitIn >= ADJ_THRESHOLD) begin
      digitOut = digitIn + ADJ_VALUE;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative signed/unsigned binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Result and done pulse follow WORD_LENGTH edges after start is sampled; start is ignored while busy.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int DIGITS      = 5
)(
  input  logic          clk,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus
);

  localparam int CW = cnt_width(WORD_LENGTH);
  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam logic [CW-1:0] CNT_INIT = CW'(WORD_LENGTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'd9}};
  localparam logic [WORD_LENGTH-1:0] MAG_ONE = WORD_LENGTH'(1);

  state_t                 state;
  logic [CW-1:0]          count;
  logic [BW-1:0]          digits;
  logic [WORD_LENGTH-1:0] mag;
  logic                   negInt;
  logic                   ovfInt;

  logic                   busyR;
  logic                   doneR;
  logic [BW-1:0]          bcdR;
  logic                   negR;
  logic                   ovfR;

  logic                   startNeg;
  logic [WORD_LENGTH-1:0] startMag;
  logic [BW-1:0]          adjDigits;
  logic [BW-1:0]          nextDigits;
  logic [WORD_LENGTH-1:0] nextMag;
  logic                   nextOvf;

  // The most negative operand negates onto itself, which read as unsigned is the right magnitude.
  assign startNeg = bus.is_signed & bus.bin[WORD_LENGTH-1];
  assign startMag = startNeg ? (~bus.bin + MAG_ONE) : bus.bin;

  for (genvar g = 0; g < DIGITS; g++) begin : gAdj
    bcd_digit_adj uAdj (
      .digitIn  (digits[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digitOut (adjDigits[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // A one leaving the top digit means the value no longer fits in DIGITS digits.
  assign nextDigits = {adjDigits[BW-2:0], mag[WORD_LENGTH-1]};
  assign nextMag    = {mag[WORD_LENGTH-2:0], 1'b0};
  assign nextOvf    = ovfInt | adjDigits[BW-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      digits <= '0;
      mag    <= '0;
      negInt <= 1'b0;
      ovfInt <= 1'b0;
      busyR  <= 1'b0;
      doneR  <= 1'b0;
      bcdR   <= '0;
      negR   <= 1'b0;
      ovfR   <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mag    <= startMag;
            negInt <= startNeg;
            digits <= '0;
            ovfInt <= 1'b0;
            count  <= CNT_INIT;
            busyR  <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          digits <= nextDigits;
          mag    <= nextMag;
          ovfInt <= nextOvf;
          count  <= count - CNT_ONE;
          if (count == '0) begin
            bcdR  <= nextOvf ? ALL_NINES : nextDigits;
            negR  <= negInt;
            ovfR  <= nextOvf;
            doneR <= 1'b1;
            busyR <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busyR;
  assign bus.done     = doneR;
  assign bus.bcd      = bcdR;
  assign bus.negative = negR;
  assign bus.ovf      = ovfR;

endmodule
